// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses 5-byte UART frames (SYNC, ADDR, DATA_HI, DATA_LO, CHK) into register writes.
// Latency: CHK strobe to cfg_wr_valid = 1 clock; the write is held until cfg_wr_ready.
// Backpressure: low cfg_wr_ready stalls in S_WRITE; bytes arriving meanwhile are dropped and counted.
// Optional: define UART_CMD_TIMEOUT_EN to abort a partial frame after TIMEOUT_CLKS byte-less clocks.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 11810,
  parameter int         CNT_W        = 8
) (
  input  logic             osc_clk,
  input  logic             rst_n,
  input  logic             rx_dv,
  input  logic [7:0]       rx_byte,
  output logic             cfg_wr_valid,
  input  logic             cfg_wr_ready,
  output logic [7:0]       cfg_wr_addr,
  output logic [15:0]      cfg_wr_data,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic             err_pulse,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DHI   = 3'd2,
    S_DLO   = 3'd3,
    S_CHK   = 3'd4,
    S_WRITE = 3'd5
  } state_t;

  state_t           r_state;
  logic [7:0]       r_chk;
  logic [7:0]       r_addr;
  logic [7:0]       r_dhi;
  logic [7:0]       r_dlo;
  logic             r_valid;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_ok_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic w_chk_bad;
  logic w_overrun;
  logic w_timeout;
  logic w_err_ev;

`ifdef UART_CMD_TIMEOUT_EN
  // Wide enough to hold TIMEOUT_CLKS-1 even for tiny TIMEOUT_CLKS values.
  localparam int TMO_W = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS + 1);

  logic [TMO_W-1:0] r_tmo;
  logic             w_in_frame;

  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DHI) ||
                      (r_state == S_DLO)  || (r_state == S_CHK);
  assign w_timeout  = w_in_frame && !rx_dv && (r_tmo == TMO_W'(TIMEOUT_CLKS - 1));

  // Inter-byte gap counter: runs only while a frame is partially received.
  always_ff @(posedge osc_clk) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (!w_in_frame || rx_dv || w_timeout) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`else
  // Without the timeout a partial frame waits forever; the parameter is kept for interface stability.
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CLKS;
  assign w_timeout    = 1'b0;
`endif

  // Error sources are mutually exclusive in practice, but OR them so any coincidence still counts once.
  always_comb begin
    w_chk_bad = (r_state == S_CHK) && rx_dv && (rx_byte != r_chk);
    w_overrun = (r_state == S_WRITE) && rx_dv;
    w_err_ev  = w_chk_bad || w_overrun || w_timeout;
  end

  // Frame parser, write handshake and saturating status counters.
  always_ff @(posedge osc_clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_chk       <= '0;
      r_addr      <= '0;
      r_dhi       <= '0;
      r_dlo       <= '0;
      r_valid     <= 1'b0;
      r_err_pulse <= 1'b0;
      r_ok_cnt    <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_err_ev;
      if (w_err_ev && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (rx_dv && (rx_byte == SYNC_BYTE)) begin
            r_chk   <= '0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_dv) begin
            r_addr  <= rx_byte;
            r_chk   <= r_chk ^ rx_byte;
            r_state <= S_DHI;
          end
        end
        S_DHI: begin
          if (rx_dv) begin
            r_dhi   <= rx_byte;
            r_chk   <= r_chk ^ rx_byte;
            r_state <= S_DLO;
          end
        end
        S_DLO: begin
          if (rx_dv) begin
            r_dlo   <= rx_byte;
            r_chk   <= r_chk ^ rx_byte;
            r_state <= S_CHK;
          end
        end
        S_CHK: begin
          if (rx_dv) begin
            if (rx_byte == r_chk) begin
              r_valid <= 1'b1;
              r_state <= S_WRITE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          // Address/data registers are frozen here, so they stay stable while valid is high.
          if (r_valid && cfg_wr_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
            if (r_ok_cnt != '1) begin
              r_ok_cnt <= r_ok_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // A stalled frame is abandoned regardless of which byte it was waiting for.
      if (w_timeout) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign cfg_wr_valid  = r_valid;
  assign cfg_wr_addr   = r_addr;
  assign cfg_wr_data   = {r_dhi, r_dlo};
  assign frame_ok_cnt  = r_ok_cnt;
  assign frame_err_cnt = r_err_cnt;
  assign err_pulse     = r_err_pulse;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame-level model (byte queue, pending write) compared every cycle,
// plus literal expectations for each directed scenario.
// Inputs driven on the falling edge; model and write monitor sample on the rising edge.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;
  localparam int CNT_W = 8;
  localparam int TMO   = 100;

  logic             osc_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_dv = 1'b0;
  logic [7:0]       rx_byte = 8'h00;
  logic             cfg_wr_ready = 1'b0;
  logic             cfg_wr_valid;
  logic [7:0]       cfg_wr_addr;
  logic [15:0]      cfg_wr_data;
  logic [CNT_W-1:0] frame_ok_cnt;
  logic [CNT_W-1:0] frame_err_cnt;
  logic             err_pulse;
  logic             busy;

  uart_cmd_ctrl #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO), .CNT_W(CNT_W)) dut (
    .osc_clk(osc_clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt),
    .err_pulse(err_pulse), .busy(busy)
  );

  always #5 osc_clk = ~osc_clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
    end
  endtask

  // Frame-level model: collected payload bytes, a pending write, and error/ok tallies.
  logic [7:0]  fq[$];
  bit          m_active = 1'b0;
  bit          m_pend = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_data = 16'h0000;
  int          m_ok = 0;
  int          m_err = 0;
  bit          m_errp = 1'b0;
  int          m_silence = 0;

  always @(posedge osc_clk) begin : model
    bit ev;
    ev = 1'b0;
    if (!rst_n) begin
      fq.delete();
      m_active = 1'b0; m_pend = 1'b0; m_addr = 8'h00; m_data = 16'h0000;
      m_ok = 0; m_err = 0; m_errp = 1'b0; m_silence = 0;
    end else begin
      if (m_pend) begin
        if (rx_dv) ev = 1'b1;
        if (cfg_wr_ready) begin
          m_pend = 1'b0;
          if (m_ok < 255) m_ok++;
        end
      end else if (m_active) begin
        if (rx_dv) begin
          m_silence = 0;
          fq.push_back(rx_byte);
          if (fq.size() == 4) begin
            if (fq[3] == (fq[0] ^ fq[1] ^ fq[2])) begin
              m_pend = 1'b1;
              m_addr = fq[0];
              m_data = {fq[1], fq[2]};
            end else begin
              ev = 1'b1;
            end
            m_active = 1'b0;
            fq.delete();
          end
        end else begin
          m_silence++;
`ifdef UART_CMD_TIMEOUT_EN
          if (m_silence == TMO) begin
            ev = 1'b1; m_active = 1'b0; fq.delete(); m_silence = 0;
          end
`endif
        end
      end else if (rx_dv && rx_byte == 8'hA5) begin
        m_active = 1'b1;
        m_silence = 0;
      end
      if (ev && m_err < 255) m_err++;
      m_errp = ev;
    end
  end

  // Observed write transfers and error pulses, for the literal scenario checks.
  logic [7:0]  wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  int          errp_seen = 0;

  always @(posedge osc_clk) begin
    if (rst_n) begin
      if (cfg_wr_valid && cfg_wr_ready) begin
        wr_addr_log.push_back(cfg_wr_addr);
        wr_data_log.push_back(cfg_wr_data);
      end
      if (err_pulse) errp_seen++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge osc_clk) begin
    if (cmp_en) begin
      chk("valid", {31'd0, cfg_wr_valid}, {31'd0, m_pend});
      chk("busy", {31'd0, busy}, {31'd0, (m_active || m_pend)});
      chk("err_pulse", {31'd0, err_pulse}, {31'd0, m_errp});
      chk("ok_cnt", {24'd0, frame_ok_cnt}, m_ok);
      chk("err_cnt", {24'd0, frame_err_cnt}, m_err);
      if (m_pend) begin
        chk("addr", {24'd0, cfg_wr_addr}, {24'd0, m_addr});
        chk("data", {16'd0, cfg_wr_data}, {16'd0, m_data});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge osc_clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    @(negedge osc_clk);
    rx_dv = 1'b0; rx_byte = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] c);
    send(8'hA5); idle(2);
    send(a);     idle(2);
    send(h);     idle(2);
    send(l);     idle(2);
    send(c);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, cfg_wr_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_errp"}, {31'd0, err_pulse}, 32'd0);
    chk({tag, "_ok"}, {24'd0, frame_ok_cnt}, 32'd0);
    chk({tag, "_err"}, {24'd0, frame_err_cnt}, 32'd0);
    chk({tag, "_addr"}, {24'd0, cfg_wr_addr}, 32'd0);
    chk({tag, "_data"}, {16'd0, cfg_wr_data}, 32'd0);
  endtask

  initial begin
    int n0;
    int p0;
    // Reset state
    idle(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(2);

    // Valid frame, ready already high: single-cycle write
    cfg_wr_ready = 1'b1;
    send_frame(8'h10, 8'h12, 8'h34, 8'h36);
    chk("f1_valid_next", {31'd0, cfg_wr_valid}, 32'd1);
    idle(4);
    chk("f1_nwr", wr_addr_log.size(), 32'd1);
    if (wr_addr_log.size() >= 1) begin
      chk("f1_addr", {24'd0, wr_addr_log[0]}, 32'h10);
      chk("f1_data", {16'd0, wr_data_log[0]}, 32'h1234);
    end
    chk("f1_ok", {24'd0, frame_ok_cnt}, 32'd1);
    chk("f1_err", {24'd0, frame_err_cnt}, 32'd0);

    // Bad checksum, then a good frame is still accepted
    p0 = errp_seen;
    send_frame(8'h10, 8'h12, 8'h34, 8'h00);
    chk("bad_busy", {31'd0, busy}, 32'd0);
    chk("bad_errp", {31'd0, err_pulse}, 32'd1);
    chk("bad_valid", {31'd0, cfg_wr_valid}, 32'd0);
    idle(4);
    chk("bad_err", {24'd0, frame_err_cnt}, 32'd1);
    chk("bad_pulses", errp_seen - p0, 32'd1);
    chk("bad_nwr", wr_addr_log.size(), 32'd1);
    send_frame(8'h10, 8'h12, 8'h34, 8'h36);
    idle(4);
    chk("after_bad_nwr", wr_addr_log.size(), 32'd2);
    chk("after_bad_ok", {24'd0, frame_ok_cnt}, 32'd2);

    // Backpressure with an overrun byte during the stall
    cfg_wr_ready = 1'b0;
    send_frame(8'h55, 8'h66, 8'h77, 8'h44);
    idle(10);
    send(8'h99);
    idle(39);
    chk("bp_valid", {31'd0, cfg_wr_valid}, 32'd1);
    chk("bp_addr", {24'd0, cfg_wr_addr}, 32'h55);
    chk("bp_data", {16'd0, cfg_wr_data}, 32'h6677);
    chk("bp_err", {24'd0, frame_err_cnt}, 32'd2);
    chk("bp_nwr", wr_addr_log.size(), 32'd2);
    cfg_wr_ready = 1'b1;
    idle(3);
    chk("bp_done_nwr", wr_addr_log.size(), 32'd3);
    if (wr_addr_log.size() >= 3) chk("bp_done_data", {16'd0, wr_data_log[2]}, 32'h6677);
    chk("bp_ok", {24'd0, frame_ok_cnt}, 32'd3);

    // Leading garbage before SYNC
    send(8'h00); idle(2);
    send(8'hFF); idle(2);
    send_frame(8'h20, 8'hAB, 8'hCD, 8'h46);
    idle(4);
    chk("garb_nwr", wr_addr_log.size(), 32'd4);
    if (wr_addr_log.size() >= 4) begin
      chk("garb_addr", {24'd0, wr_addr_log[3]}, 32'h20);
      chk("garb_data", {16'd0, wr_data_log[3]}, 32'hABCD);
    end
    chk("garb_err", {24'd0, frame_err_cnt}, 32'd2);

    // SYNC value used as payload
    send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5);
    idle(4);
    chk("syncpay_nwr", wr_addr_log.size(), 32'd5);
    if (wr_addr_log.size() >= 5) chk("syncpay_data", {16'd0, wr_data_log[4]}, 32'hA5A5);

    // Stalled frame: SYNC, ADDR, then silence
    send(8'hA5); idle(2);
    send(8'h10);
    idle(150);
`ifdef UART_CMD_TIMEOUT_EN
    chk("tmo_err", {24'd0, frame_err_cnt}, 32'd3);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
`else
    chk("tmo_err", {24'd0, frame_err_cnt}, 32'd2);
    chk("tmo_busy", {31'd0, busy}, 32'd1);
`endif
    rst_n = 1'b0;
    idle(1);
    chk_all_zero("rst2");
    rst_n = 1'b1;
    idle(2);

    // Reset after DATA_HI abandons the frame
    n0 = wr_addr_log.size();
    p0 = errp_seen;
    send(8'hA5); idle(2);
    send(8'h12); idle(2);
    send(8'h34);
    rst_n = 1'b0;
    idle(1);
    chk_all_zero("midrst");
    rst_n = 1'b1;
    idle(2);
    send(8'h56); idle(2);
    send(8'h70);
    idle(5);
    chk("midrst_nwr", wr_addr_log.size() - n0, 32'd0);
    chk("midrst_pulses", errp_seen - p0, 32'd0);
    chk("midrst_err", {24'd0, frame_err_cnt}, 32'd0);
    chk("midrst_ok", {24'd0, frame_ok_cnt}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
